// File: rtl/tlut_pkg.sv
// Shared types for the temporal-LUT stages: sequencer state enum and default lane geometry.
// Lane geometry comes from the project-wide DEF macros when present.
`ifndef DIM_C
`define DIM_C 2
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 20
`endif

package tlut_pkg;

    localparam int unsigned DefDimC        = `DIM_C;
    localparam int unsigned DefWeightWidth = `WEIGHT_WIDTH;
    localparam int unsigned DefAccWidth    = `ACC_WIDTH;
    localparam int unsigned DefActWidth    = 4;

    typedef logic [DefDimC-1:0][DefWeightWidth-1:0] weight_vec_t;
    typedef logic [DefDimC-1:0][DefAccWidth-1:0]    sum_vec_t;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StOut
    } seq_state_t;

endpackage

// File: rtl/tlut_pulse_counter.sv
// Loadable down-counter that paces pulse trains in temporal stages.
module tlut_pulse_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] value_o,
    output logic             is_one_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            // Saturate at zero so a stray decrement cannot wrap into a long train.
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o  = cnt_q;
    assign is_one_o = (cnt_q == Width'(1));

endmodule

// File: rtl/tlut_weight_sequencer.sv
// Drives an accumulator with A enabled cycles of W per term, then captures,
// clears and hands off the dot-product sums under valid/ready.
module tlut_weight_sequencer
    import tlut_pkg::*;
#(
    parameter int unsigned DIM_C        = DefDimC,
    parameter int unsigned WEIGHT_WIDTH = DefWeightWidth,
    parameter int unsigned ACC_WIDTH    = DefAccWidth,
    parameter int unsigned ACT_WIDTH    = DefActWidth
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ACT_WIDTH-1:0]          in_act_i,
    input  logic [DIM_C*WEIGHT_WIDTH-1:0] in_weight_i,
    input  logic                          in_last_i,
    output logic                          acc_enable_o,
    output logic                          acc_clear_o,
    output logic [DIM_C*WEIGHT_WIDTH-1:0] acc_val_o,
    input  logic [DIM_C*ACC_WIDTH-1:0]    acc_sum_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DIM_C*ACC_WIDTH-1:0]    out_sum_o
);

    seq_state_t                    state_d, state_q;
    logic [DIM_C*WEIGHT_WIDTH-1:0] weight_d, weight_q;
    logic                          last_d, last_q;
    logic [DIM_C*ACC_WIDTH-1:0]    out_sum_d, out_sum_q;

    logic                 cnt_load;
    logic                 cnt_dec;
    logic [ACT_WIDTH-1:0] cnt_value;
    logic                 cnt_is_one;

    tlut_pulse_counter #(
        .Width (ACT_WIDTH)
    ) u_pulse_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (in_act_i),
        .dec_i      (cnt_dec),
        .value_o    (cnt_value),
        .is_one_o   (cnt_is_one)
    );

    always_comb begin
        state_d      = state_q;
        weight_d     = weight_q;
        last_d       = last_q;
        out_sum_d    = out_sum_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        in_ready_o   = 1'b0;
        acc_enable_o = 1'b0;
        acc_clear_o  = 1'b0;
        out_valid_o  = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    weight_d = in_weight_i;
                    last_d   = in_last_i;
                    cnt_load = 1'b1;
                    if (in_act_i != '0) begin
                        state_d = StStream;
                    end else if (in_last_i) begin
                        state_d = StFlush;
                    end
                end
            end
            StStream: begin
                acc_enable_o = 1'b1;
                cnt_dec      = 1'b1;
                if (cnt_is_one) begin
                    state_d = last_q ? StFlush : StIdle;
                end
            end
            StFlush: begin
                // The accumulator clears at this cycle's edge, after the sum is captured.
                acc_clear_o = 1'b1;
                out_sum_d   = acc_sum_i;
                state_d     = StOut;
            end
            StOut: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        acc_val_o = acc_enable_o ? weight_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            weight_q  <= '0;
            last_q    <= 1'b0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            weight_q  <= weight_d;
            last_q    <= last_d;
            out_sum_q <= out_sum_d;
        end
    end

    assign out_sum_o = out_sum_q;

`ifndef SYNTHESIS
    a_en_clr_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(acc_enable_o && acc_clear_o));
    a_stream_cnt : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StStream) |-> (cnt_value != '0));
`endif

endmodule

// File: tb/tb_tlut_weight_sequencer.sv
// Directed and randomised bench for tlut_weight_sequencer with a behavioural accumulator.
module tb_tlut_weight_sequencer;

    localparam int unsigned DC = 2;
    localparam int unsigned WW = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned TW = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [TW-1:0]   in_act;
    logic [DC*WW-1:0] in_weight;
    logic            in_last;
    logic            acc_enable;
    logic            acc_clear;
    logic [DC*WW-1:0] acc_val;
    logic [DC*AW-1:0] acc_sum;
    logic            out_valid;
    logic            out_ready;
    logic [DC*AW-1:0] out_sum;

    int n_cmp = 0;
    int n_err = 0;

    tlut_weight_sequencer #(
        .DIM_C        (DC),
        .WEIGHT_WIDTH (WW),
        .ACC_WIDTH    (AW),
        .ACT_WIDTH    (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_act_i     (in_act),
        .in_weight_i  (in_weight),
        .in_last_i    (in_last),
        .acc_enable_o (acc_enable),
        .acc_clear_o  (acc_clear),
        .acc_val_o    (acc_val),
        .acc_sum_i    (acc_sum),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_sum_o    (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator_weight stand-in, sharing the same reset.
    logic [DC-1:0][AW-1:0] acc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (acc_clear) begin
            acc_q <= '0;
        end else if (acc_enable) begin
            for (int i = 0; i < DC; i++) begin
                acc_q[i] <= acc_q[i] + AW'(acc_val[i*WW +: WW]);
            end
        end
    end
    assign acc_sum = acc_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("en_clr_excl", 64'(acc_enable && acc_clear), 64'd0);
            chk("val_gated", 64'(!acc_enable && (acc_val != '0)), 64'd0);
        end
    end

    // Entered and left at a negedge; for last terms it ends on the first OUT cycle.
    task automatic send_term(input logic [TW-1:0] a, input logic [WW-1:0] w0,
                             input logic [WW-1:0] w1, input logic last, input int gap);
        int t;
        int pulses;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_act    = a;
        in_weight = {w1, w0};
        in_last   = last;
        @(negedge clk);
        in_valid  = 1'b0;
        in_act    = TW'($urandom);
        in_weight = DC*WW'($urandom);
        in_last   = 1'($urandom);
        pulses = 0;
        while (acc_enable && pulses < 40) begin
            pulses++;
            chk("acc_val", 64'(acc_val), 64'({w1, w0}));
            chk("stream_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        chk("pulse_count", 64'(pulses), 64'(a));
        if (last) begin
            chk("flush_clear", 64'(acc_clear), 64'd1);
            chk("flush_nvalid", 64'(out_valid), 64'd0);
            @(negedge clk);
            chk("out_clear", 64'(acc_clear), 64'd0);
            chk("out_latency", 64'(out_valid), 64'd1);
        end else begin
            chk("idle_ready", 64'(in_ready), 64'd1);
            chk("idle_clear", 64'(acc_clear), 64'd0);
        end
    endtask

    task automatic drain(input int stall, input logic [AW-1:0] e0, input logic [AW-1:0] e1);
        chk("out_valid", 64'(out_valid), 64'd1);
        chk("out_sum", 64'(out_sum), 64'({e1, e0}));
        for (int s = 0; s < stall; s++) begin
            in_valid  = 1'($urandom);
            in_act    = TW'($urandom);
            in_weight = DC*WW'($urandom);
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_sum", 64'(out_sum), 64'({e1, e0}));
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk("stall_enable", 64'(acc_enable), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drained_valid", 64'(out_valid), 64'd0);
        chk("drained_ready", 64'(in_ready), 64'd1);
        chk("drained_acc", 64'(acc_sum), 64'd0);
    endtask

    typedef struct {
        int               n;
        logic [2:0][TW-1:0] a;
        logic [2:0][WW-1:0] w0;
        logic [2:0][WW-1:0] w1;
        int               stall;
        logic [AW-1:0]    e0;
        logic [AW-1:0]    e1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [AW-1:0] e0, e1;
        int            n;
        logic [TW-1:0] a;
        logic [WW-1:0] w0, w1;

        vecs[0] = '{n: 1, a: {4'd0, 4'd0, 4'd3}, w0: {8'd0, 8'd0, 8'd5},
                    w1: {8'd0, 8'd0, 8'd7}, stall: 0, e0: 20'd15, e1: 20'd21};
        vecs[1] = '{n: 3, a: {4'd4, 4'd0, 4'd2}, w0: {8'd3, 8'd9, 8'd1},
                    w1: {8'd1, 8'd9, 8'd2}, stall: 1, e0: 20'd14, e1: 20'd8};
        vecs[2] = '{n: 1, a: {4'd0, 4'd0, 4'd2}, w0: {8'd0, 8'd0, 8'd4},
                    w1: {8'd0, 8'd0, 8'd6}, stall: 10, e0: 20'd8, e1: 20'd12};
        vecs[3] = '{n: 1, a: {4'd0, 4'd0, 4'd15}, w0: {8'd0, 8'd0, 8'd255},
                    w1: {8'd0, 8'd0, 8'd255}, stall: 0, e0: 20'd3825, e1: 20'd3825};
        vecs[4] = '{n: 1, a: {4'd0, 4'd0, 4'd0}, w0: {8'd0, 8'd0, 8'd77},
                    w1: {8'd0, 8'd0, 8'd99}, stall: 2, e0: 20'd0, e1: 20'd0};
        vecs[5] = '{n: 1, a: {4'd0, 4'd0, 4'd1}, w0: {8'd0, 8'd0, 8'd1},
                    w1: {8'd0, 8'd0, 8'd1}, stall: 0, e0: 20'd1, e1: 20'd1};
        vecs[6] = '{n: 3, a: {4'd5, 4'd2, 4'd1}, w0: {8'd7, 8'd3, 8'd10},
                    w1: {8'd0, 8'd4, 8'd20}, stall: 3, e0: 20'd51, e1: 20'd28};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_act    = '0;
        in_weight = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_enable", 64'(acc_enable), 64'd0);
        chk("rst_clear", 64'(acc_clear), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_val", 64'(acc_val), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int t = 0; t < vecs[v].n; t++) begin
                send_term(vecs[v].a[t], vecs[v].w0[t], vecs[v].w1[t], t == vecs[v].n - 1, 0);
            end
            drain(vecs[v].stall, vecs[v].e0, vecs[v].e1);
        end

        // Reset after 4 of 10 pulses, then a clean term afterwards.
        in_valid  = 1'b1;
        in_act    = 4'd10;
        in_weight = {8'd1, 8'd1};
        in_last   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_enable", 64'(acc_enable), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_enable", 64'(acc_enable), 64'd0);
        chk("mid_rst_clear", 64'(acc_clear), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_val", 64'(acc_val), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_enable", 64'(acc_enable), 64'd0);
        send_term(4'd1, 8'd2, 8'd3, 1'b1, 0);
        drain(0, 20'd2, 20'd3);

        for (int d = 0; d < 200; d++) begin
            n  = $urandom_range(1, 3);
            e0 = '0;
            e1 = '0;
            for (int t = 0; t < n; t++) begin
                a  = TW'($urandom_range(0, 15));
                w0 = WW'($urandom);
                w1 = WW'($urandom);
                e0 = e0 + AW'(a) * AW'(w0);
                e1 = e1 + AW'(a) * AW'(w1);
                send_term(a, w0, w1, t == n - 1, $urandom_range(0, 2));
            end
            drain($urandom_range(0, 3), e0, e1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
